// File: rtl/ffsr_pkg.sv
// Shared constants, FSM state type and index-width helper for the FFSR decoder slice.
// Imported by the one-hot encoder and the pulse decoder top.
package ffsr_pkg;

  localparam int FFSR_N = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    EMIT_HI = 3'd2,
    EMIT_LO = 3'd3,
    RESULT  = 3'd4
  } ffsr_state_t;

  // Index width for an n-stage FFSR; never narrower than one bit.
  function automatic int ffsr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ffsr_onehot_enc.sv
// Combinational one-hot encoder: index of the lowest set bit plus an exactly-one-hot flag.
// Zero latency, no state.
module ffsr_onehot_enc
  import ffsr_pkg::*;
#(
  parameter int N = FFSR_N,
  parameter int W = ffsr_idx_w(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         onehot_ok_o
);

  logic [N-1:0] vec_m1;

  // Scan downward so the lowest set bit is the last assignment to stick.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign vec_m1      = vec_i - N'(1);
  assign onehot_ok_o = (vec_i != '0) && ((vec_i & vec_m1) == '0);

endmodule

// File: rtl/ffsr_pulse_decoder.sv
// Snapshots the FFSR one-hot state, decodes it to a binary index, replays the index as a
// unary pulse train and returns idx/err over a valid/ready handshake.
module ffsr_pulse_decoder
  import ffsr_pkg::*;
#(
  parameter int N = FFSR_N,
  parameter int W = ffsr_idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ffsr_state_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         pulse_o,
  output logic [W-1:0] idx_o,
  output logic         err_o,
  output logic         idx_valid_o,
  input  logic         idx_ready_i
);

  ffsr_state_t  state_q, state_d;
  logic [N-1:0] snap_q, snap_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] idx_q, idx_d;
  logic         err_q, err_d;
  logic         dec_q, dec_d;

  logic [W-1:0] enc_idx;
  logic         enc_ok;

  ffsr_onehot_enc #(.N(N), .W(W)) u_enc (
    .vec_i       (snap_q),
    .idx_o       (enc_idx),
    .onehot_ok_o (enc_ok)
  );

  // DECODE spends one cycle registering idx/err/cnt and a second branching on the
  // registered result, so the pulse train starts two edges after the start edge.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          snap_d  = ffsr_state_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!dec_q) begin
          idx_d = enc_ok ? enc_idx : '0;
          cnt_d = enc_ok ? enc_idx : '0;
          err_d = !enc_ok;
          dec_d = 1'b1;
        end else begin
          dec_d   = 1'b0;
          state_d = (err_q || (idx_q == '0)) ? RESULT : EMIT_HI;
        end
      end
      EMIT_HI: begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
        state_d = EMIT_LO;
      end
      EMIT_LO: begin
        state_d = (cnt_q == '0) ? RESULT : EMIT_HI;
      end
      RESULT: begin
        if (idx_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      dec_q   <= dec_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign pulse_o     = (state_q == EMIT_HI);
  assign idx_valid_o = (state_q == RESULT);
  assign idx_o       = idx_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ffsr_pulse_decoder.sv
// Self-checking bench for ffsr_pulse_decoder: table-driven directed runs, a reset-abort
// sequence and randomized runs checked against a behavioural model.
module tb_ffsr_pulse_decoder;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ffsr_state;
  logic         start;
  logic         busy;
  logic         pulse;
  logic [W-1:0] idx;
  logic         err;
  logic         idx_valid;
  logic         idx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  ffsr_pulse_decoder #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .ffsr_state_i (ffsr_state),
    .start_i      (start),
    .busy_o       (busy),
    .pulse_o      (pulse),
    .idx_o        (idx),
    .err_o        (err),
    .idx_valid_o  (idx_valid),
    .idx_ready_i  (idx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic [N-1:0] s2;
    int           stall;
    int           exp_idx;
    int           exp_err;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: index of the single set bit, or an error with index 0.
  function automatic void model(input logic [N-1:0] s, output int k, output int e);
    int ones;
    ones = 0;
    k    = 0;
    for (int b = 0; b < N; b++) begin
      if (s[b]) begin
        if (ones == 0) k = b;
        ones++;
      end
    end
    e = (ones != 1) ? 1 : 0;
    if (e != 0) k = 0;
  endfunction

  // One full decode: start on s, swap the input to s2 right after capture, stall the
  // consumer for `stall` cycles once idx_valid rises, and check every observable.
  task automatic run_decode(input string nm, input logic [N-1:0] s, input logic [N-1:0] s2,
                            input int stall, input int k, input int e);
    int j, npulse, vj, bad_pat, bad_stall;
    bit exp_p;
    ffsr_state = s;
    start      = 1'b1;
    idx_ready  = (stall == 0);
    tick();
    start      = 1'b0;
    ffsr_state = s2;
    j = 0; npulse = 0; vj = -1; bad_pat = 0;
    while (vj < 0 && j < 80) begin
      exp_p = (j >= 2) && (j <= 2 * k) && (j % 2 == 0);
      if (busy !== 1'b1) bad_pat++;
      if (pulse !== exp_p) bad_pat++;
      if (pulse === 1'b1) npulse++;
      if (idx_valid === 1'b1) vj = j;
      else begin
        tick();
        j++;
      end
    end
    check({nm, "_pulses"}, npulse, k);
    check({nm, "_valid_lat"}, vj, 2 * k + 2);
    check({nm, "_pattern_errs"}, bad_pat, 0);
    check({nm, "_idx"}, int'(idx), k);
    check({nm, "_err"}, int'(err), e);
    bad_stall = 0;
    for (int c = 0; c < stall; c++) begin
      start      = (c == stall / 2);
      ffsr_state = 16'h0001;
      tick();
      if (idx_valid !== 1'b1 || busy !== 1'b1 || pulse !== 1'b0) bad_stall++;
      if (int'(idx) != k || int'(err) != e) bad_stall++;
    end
    if (stall > 0) check({nm, "_stall_errs"}, bad_stall, 0);
    start     = 1'b0;
    idx_ready = 1'b1;
    tick();
    check({nm, "_done_valid"}, int'(idx_valid), 0);
    check({nm, "_done_busy"}, int'(busy), 0);
    check({nm, "_hold_idx"}, int'(idx), k);
    idx_ready = 1'b0;
    tick();
    check({nm, "_idle_busy"}, int'(busy), 0);
  endtask

  vec_t tbl[7];

  initial begin
    int k, e;
    logic [N-1:0] s, s2;

    tbl[0] = '{16'h0020, 16'h0020, 0, 5, 0};
    tbl[1] = '{16'h0001, 16'h0001, 0, 0, 0};
    tbl[2] = '{16'h8000, 16'h8000, 0, 15, 0};
    tbl[3] = '{16'h0000, 16'h0000, 0, 0, 1};
    tbl[4] = '{16'h0410, 16'h0410, 0, 0, 1};
    tbl[5] = '{16'h0008, 16'h0008, 10, 3, 0};
    tbl[6] = '{16'h0008, 16'h0100, 0, 3, 0};

    rst        = 1'b1;
    start      = 1'b0;
    idx_ready  = 1'b0;
    ffsr_state = '0;
    #3;
    check("reset_busy", int'(busy), 0);
    check("reset_pulse", int'(pulse), 0);
    check("reset_valid", int'(idx_valid), 0);
    check("reset_idx", int'(idx), 0);
    check("reset_err", int'(err), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_decode($sformatf("tbl%0d", i), tbl[i].s, tbl[i].s2, tbl[i].stall,
                 tbl[i].exp_idx, tbl[i].exp_err);
    end

    // Reset during the second high cycle of an idx=6 pulse train.
    ffsr_state = 16'h0040;
    start      = 1'b1;
    idx_ready  = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("abort_pre_pulse", int'(pulse), 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_pulse", int'(pulse), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(idx_valid), 0);
    tick();
    rst = 1'b0;
    check("abort_idx", int'(idx), 0);
    tick();
    run_decode("after_abort", 16'h0004, 16'h0004, 0, 2, 0);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(3) == 0) s = N'($urandom);
      else s = N'(1) << $urandom_range(N - 1);
      s2 = N'($urandom);
      model(s, k, e);
      run_decode($sformatf("rnd%0d", r), s, s2, int'($urandom_range(3)), k, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ffsr_pulse_decoder.md
# ffsr_pulse_decoder

Reader side of the FFSR pulse-encoding chain. Snapshots the N-stage one-hot FFSR state vector on request and validates it as exactly one-hot. Converts the active stage position to a binary index and replays that index downstream as a unary pulse train. Returns the binary index and an error flag over a valid/ready handshake, closing the loop between the FFSR array and binary-domain logic.

## Interface
- N, 16, number of FFSR stages (≥2)
- W, $clog2(N), index width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- ffsr_state  input  N  one-hot FFSR stage outputs; bit i = stage i
- start  input  1  request a decode; sampled only in IDLE
- busy  output  1  high from accepted start until the result is consumed
- pulse  output  1  unary pulse train, one high cycle per index unit
- idx  output  W  decoded stage index
- err  output  1  snapshot was not exactly one-hot
- idx_valid  output  1  idx/err valid
- idx_ready  input  1  consumer accepts idx/err

## Operation
- FSM states: IDLE, DECODE, EMIT_HI, EMIT_LO, RESULT.
- IDLE: if start=1, register ffsr_state into snap, then go to DECODE. busy=1 from this edge.
- DECODE: register idx=position of the single set bit of snap and err=(popcount(snap)≠1). Load remaining-pulse counter cnt=idx (W bits).
  - If err=1: force idx=0 and go to RESULT with no pulses.
  - If idx=0: go to RESULT.
  - Otherwise go to EMIT_HI.
- EMIT_HI: pulse=1, cnt decrements, then go to EMIT_LO.
- EMIT_LO: pulse=0. If cnt=0, go to RESULT; otherwise go to EMIT_HI.
- Pulse duty: strictly alternating high and low, so every pulse is a distinct rising edge. Exactly idx pulses are emitted.
- RESULT: idx_valid=1. idx and err are held stable.
  - When idx_valid & idx_ready are sampled high, go to IDLE. idx_valid and busy drop at that edge.
  - idx and err retain their last values in IDLE.
- start while not in IDLE is ignored and not queued.
- Changes on ffsr_state after capture have no effect on the current decode.
- Reset: asynchronous and immediate from any state, including mid-EMIT. FSM=IDLE; snap=0, cnt=0, idx=0, err=0, pulse=0, busy=0, idx_valid=0. A partial pulse train is abandoned with no result.
- Index arithmetic: idx ranges 0..N-1 and never wraps. cnt is W bits and decrements only from nonzero values.

## Timing
- Start accepted at edge t: busy=1 after t. Decode registered at edge t+1.
- For k=idx>0: pulse high during cycles after edges t+2, t+4, …, t+2k. RESULT is entered at edge t+2k+2, and idx_valid=1 after that edge.
- For k=0 or err=1: idx_valid=1 after edge t+2.
- Request-to-result latency: 2k+2 cycles, plus any handshake stall.
- With idx_ready held high, the block returns to IDLE one cycle after idx_valid rises. The next start is accepted at the following edge, giving a minimum back-to-back period of 2k+4 cycles.
- No combinational path from any input to any output. All outputs are registers or decodes of the FSM state register.

## Structure
- Shared package ffsr_pkg holds:
  - FFSR_N default constant (16)
  - the FSM state enum typedef (IDLE, DECODE, EMIT_HI, EMIT_LO, RESULT)
  - a function computing index width from N
- Sub-module ffsr_onehot_enc, purely combinational:
  - input: N-bit vector
  - outputs: W-bit index of the lowest set bit, and a onehot_ok flag (popcount==1)
- The top level holds the FSM, snapshot register, cnt, and output registers.

## Test plan
- N=16, ffsr_state=16'h0020, start pulse, idx_ready=1 → exactly 5 pulse highs on alternating cycles; idx=5, err=0; idx_valid rises 12 cycles after the start edge and is high for 1 cycle.
- ffsr_state=16'h0001 → no pulses; idx=0, err=0; idx_valid 2 cycles after start. ffsr_state=16'h8000 → 15 pulses; idx=15.
- ffsr_state=16'h0000, then 16'h0410 → both runs: err=1, idx=0, zero pulses, idx_valid after 2 cycles.
- idx=3 decode with idx_ready=0 for 10 cycles: idx_valid, idx and busy stay stable. A start pulse during the stall is ignored. Raising idx_ready gives exactly one completion, then IDLE.
- Change ffsr_state from 16'h0008 to 16'h0100 one cycle after start → 3 pulses, idx=3.
- Assert rst during the second EMIT_HI of an idx=6 decode → pulse, busy and idx_valid go 0 immediately. After release, a new start with 16'h0004 yields 2 pulses and idx=2.
